// File: rtl/conv1_channel_sched.sv
// conv1_channel_sched: time-shares one 3x3 conv1 filter engine across all
// output channels. One window is accepted, then each channel's weights and
// bias are streamed from the weight memory into the engine, one channel per
// cycle. Results come back in channel order with window and frame markers.
//
// Handshake: a window transfers on the rising edge where win_valid and
// win_ready are both high (and clear is low). win_ready is high only in IDLE.
// The source must hold win_data stable until that edge. out_valid has no
// backpressure; the downstream must accept a result on every cycle it is high.
module conv1_channel_sched #(
  parameter int CHANNELS = 32,
  parameter int PIPE_LAT = 12,
  parameter int NUM_WIN  = 676,
  localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int WW = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          win_valid,
  output logic          win_ready,
  input  logic [287:0]  win_data,
  output logic          w_rd_en,
  output logic [AW-1:0] w_addr,
  input  logic [319:0]  w_rdata,
  output logic          eng_valid,
  output logic [287:0]  eng_data,
  output logic [287:0]  eng_weight,
  output logic [31:0]   eng_bias,
  input  logic [31:0]   eng_result,
  output logic          out_valid,
  output logic [31:0]   out_data,
  output logic [AW-1:0] out_ch,
  output logic          out_win_last,
  output logic          out_frame_last,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_CH  = AW'(CHANNELS - 1);
  localparam logic [WW-1:0] LAST_WIN = WW'(NUM_WIN - 1);

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   issue_cnt;
  logic [AW-1:0]   eng_ch;
  logic [PIPE_LAT-1:0] tag_v;
  logic [AW-1:0]   tag_ch [PIPE_LAT];
  logic            tag_busy;
  logic [WW-1:0]   win_cnt;
  logic            accept;

  assign tag_busy  = |tag_v;
  assign accept    = win_valid & win_ready & ~clear;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Read address is only meaningful during a read strobe; idle value is 0.
  assign w_addr = w_rd_en ? issue_cnt : '0;

  // Memory data arrives one cycle after the strobe, aligned with eng_valid.
  assign eng_weight = eng_valid ? w_rdata[287:0]   : '0;
  assign eng_bias   = eng_valid ? w_rdata[319:288] : '0;

  assign out_win_last   = out_valid & (out_ch == LAST_CH);
  assign out_frame_last = out_win_last & (win_cnt == LAST_WIN);

  // State register; clear aborts to IDLE like a synchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_next = state;
    win_ready  = 1'b0;
    w_rd_en    = 1'b0;
    case (state)
      IDLE: begin
        win_ready = 1'b1;
        if (win_valid) state_next = RUN;
      end
      RUN: begin
        w_rd_en = 1'b1;
        if (issue_cnt == LAST_CH) state_next = DRAIN;
      end
      DRAIN: begin
        // The last result leaves the output register on the same edge.
        if (!tag_busy && !eng_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Issue counter, window latch and the one-cycle issue stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      eng_data  <= '0;
      eng_valid <= 1'b0;
      eng_ch    <= '0;
    end else if (clear) begin
      issue_cnt <= '0;
      eng_data  <= '0;
      eng_valid <= 1'b0;
      eng_ch    <= '0;
    end else begin
      eng_valid <= w_rd_en;
      eng_ch    <= w_rd_en ? issue_cnt : '0;
      if (accept) begin
        eng_data  <= win_data;
        issue_cnt <= '0;
      end else if (w_rd_en) begin
        issue_cnt <= (issue_cnt == LAST_CH) ? '0 : issue_cnt + AW'(1);
      end
    end
  end

  // Tag pipeline: follows each issued channel through the engine latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_v[i]  <= 1'b0;
        tag_ch[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_v[i]  <= 1'b0;
        tag_ch[i] <= '0;
      end
    end else begin
      tag_v[0]  <= eng_valid;
      tag_ch[0] <= eng_ch;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_ch[i] <= tag_ch[i-1];
      end
    end
  end

  // Output register: captures the engine result as its tag exits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      out_valid <= tag_v[PIPE_LAT-1];
      if (tag_v[PIPE_LAT-1]) begin
        out_data <= eng_result;
        out_ch   <= tag_ch[PIPE_LAT-1];
      end
    end
  end

  // Window counter within a frame; advances on each window's last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (clear) begin
      win_cnt <= '0;
    end else if (out_win_last) begin
      win_cnt <= out_frame_last ? '0 : win_cnt + WW'(1);
    end
  end

endmodule

// File: tb/tb_conv1_channel_sched.sv
// Bench for conv1_channel_sched: memory and engine responders, a driver,
// a protocol checker that also pushes expected results, and an output
// monitor that pops and compares them.
module tb_conv1_channel_sched;

  localparam int CH = 32;
  localparam int PL = 12;
  localparam int NW = 4;
  localparam int AW = 5;
  localparam int W  = 32 + 32 + AW + 2;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          win_valid;
  logic          win_ready;
  logic [287:0]  win_data;
  logic          w_rd_en;
  logic [AW-1:0] w_addr;
  logic [319:0]  w_rdata;
  logic          eng_valid;
  logic [287:0]  eng_data;
  logic [287:0]  eng_weight;
  logic [31:0]   eng_bias;
  logic [31:0]   eng_result;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [AW-1:0] out_ch;
  logic          out_win_last;
  logic          out_frame_last;
  logic          busy;
  logic [1:0]    dbg_state;

  conv1_channel_sched #(.CHANNELS(CH), .PIPE_LAT(PL), .NUM_WIN(NW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .eng_valid(eng_valid), .eng_data(eng_data), .eng_weight(eng_weight),
    .eng_bias(eng_bias), .eng_result(eng_result),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_win_last(out_win_last), .out_frame_last(out_frame_last),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [319:0] mem [CH];
  logic [31:0]  eng_pipe [PL];
  bit           active = 0;
  int           t_hs = 0;
  int           hs_count = 0;
  int           win_idx = 0;
  logic [287:0] cur_win = '0;

  // ---------------- helpers ----------------
  function automatic logic [31:0] i2f(input int n);
    int e;
    logic [31:0] m;
    if (n <= 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 31; b++) if (((n >> b) & 1) != 0) e = b;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] v);
    int e;
    logic [31:0] m;
    if (v[30:23] == 8'd0) return 0;
    e = int'(v[30:23]) - 127;
    m = {8'd0, 1'b1, v[22:0]};
    return int'(m >> (23 - e));
  endfunction

  // Single-float 3x3 dot product plus bias, for small non-negative integers.
  function automatic logic [31:0] engine_f(input logic [287:0] d,
                                           input logic [287:0] w,
                                           input logic [31:0] b);
    int s;
    s = f2i(b);
    for (int i = 0; i < 9; i++) s += f2i(d[32*i +: 32]) * f2i(w[32*i +: 32]);
    return i2f(s);
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [287:0] rand_win();
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[32*i +: 32] = i2f(int'($urandom_range(0, 7)));
    return r;
  endfunction

  task automatic rand_mem();
    for (int k = 0; k < CH; k++) begin
      for (int i = 0; i < 9; i++) mem[k][32*i +: 32] = i2f(int'($urandom_range(0, 7)));
      mem[k][319:288] = i2f(int'($urandom_range(0, 100)));
    end
  endtask

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- responders ----------------
  // Weight memory: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) w_rdata <= w_rd_en ? mem[w_addr] : rand320();

  // Engine: fixed PL-cycle latency, garbage when not issued.
  always @(posedge clk) begin
    eng_pipe[0] <= eng_valid ? engine_f(eng_data, eng_weight, eng_bias) : $urandom;
    for (int i = 1; i < PL; i++) eng_pipe[i] <= eng_pipe[i-1];
  end
  assign eng_result = eng_pipe[PL-1];

  // ---------------- protocol checker + expected-result producer ----------------
  always @(negedge clk) begin
    int e;
    int rel;
    int s;
    logic exp_busy, exp_rd, exp_ev, wl, fl;
    logic [AW-1:0] exp_addr;
    logic [287:0]  exp_w;
    logic [31:0]   exp_b;
    if (rst_n) begin
      e = cyc + 1;
      rel = active ? e - t_hs : 0;
      exp_busy = active && rel >= 1 && rel <= CH + PL + 2;
      exp_rd   = active && rel >= 1 && rel <= CH;
      exp_ev   = active && rel >= 2 && rel <= CH + 1;
      exp_addr = exp_rd ? AW'(rel - 1) : '0;
      if (exp_ev) begin
        exp_w = mem[rel-2][287:0];
        exp_b = mem[rel-2][319:288];
      end else begin
        exp_w = '0;
        exp_b = '0;
      end
      chk("win_ready", 320'(win_ready), 320'(!exp_busy));
      chk("busy", 320'(busy), 320'(exp_busy));
      chk("w_rd_en", 320'(w_rd_en), 320'(exp_rd));
      chk("w_addr", 320'(w_addr), 320'(exp_addr));
      chk("eng_valid", 320'(eng_valid), 320'(exp_ev));
      chk("eng_weight", 320'(eng_weight), 320'(exp_w));
      chk("eng_bias", 320'(eng_bias), 320'(exp_b));
      chk("eng_data", 320'(eng_data), 320'(cur_win));
      if (active && rel >= CH + PL + 2) active = 0;
      if (win_valid && !clear && !exp_busy) begin
        t_hs = e;
        active = 1;
        cur_win = win_data;
        hs_count++;
        for (int k = 0; k < CH; k++) begin
          s = f2i(mem[k][319:288]);
          for (int i = 0; i < 9; i++) s += f2i(win_data[32*i +: 32]) * f2i(mem[k][32*i +: 32]);
          wl = (k == CH - 1);
          fl = wl && (win_idx == NW - 1);
          exp_q.push_back({32'(e + PL + 3 + k), i2f(s), AW'(k), wl, fl});
        end
        win_idx = (win_idx + 1) % NW;
      end
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] ent;
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out at cycle %0d: ch=%0d data=%h, no result expected",
                   cyc, out_ch, out_data);
        end else begin
          ent = exp_q.pop_front();
          chk("out_cycle", 320'(cyc + 1), 320'(ent[W-1 -: 32]));
          chk("out_data", 320'(out_data), 320'(ent[W-33 -: 32]));
          chk("out_ch", 320'(out_ch), 320'(ent[AW+1:2]));
          chk("out_win_last", 320'(out_win_last), 320'(ent[1]));
          chk("out_frame_last", 320'(out_frame_last), 320'(ent[0]));
        end
      end else begin
        chk("win_last_idle", 320'(out_win_last), 320'(0));
        chk("frame_last_idle", 320'(out_frame_last), 320'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_hs(output int t, input int budget);
    int n0;
    int i;
    n0 = hs_count;
    i = 0;
    while (hs_count == n0 && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("handshake_timeout", 320'(hs_count == n0), 320'(0));
    t = (hs_count == n0) ? -1000 : t_hs;
  endtask

  task automatic send_window(input logic [287:0] d, output int t);
    win_data = d;
    win_valid = 1'b1;
    wait_hs(t, 200);
    win_valid = 1'b0;
    win_data = rand_win();
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (active && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("idle_timeout", 320'(active), 320'(0));
  endtask

  task automatic model_reset();
    exp_q.delete();
    active = 0;
    cur_win = '0;
    win_idx = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_win_ready"}, 320'(win_ready), 320'(1));
    chk({tag, "_busy"}, 320'(busy), 320'(0));
    chk({tag, "_w_rd_en"}, 320'(w_rd_en), 320'(0));
    chk({tag, "_w_addr"}, 320'(w_addr), 320'(0));
    chk({tag, "_eng_valid"}, 320'(eng_valid), 320'(0));
    chk({tag, "_eng_data"}, 320'(eng_data), 320'(0));
    chk({tag, "_eng_weight"}, 320'(eng_weight), 320'(0));
    chk({tag, "_eng_bias"}, 320'(eng_bias), 320'(0));
    chk({tag, "_out_valid"}, 320'(out_valid), 320'(0));
    chk({tag, "_out_data"}, 320'(out_data), 320'(0));
    chk({tag, "_out_ch"}, 320'(out_ch), 320'(0));
    chk({tag, "_out_win_last"}, 320'(out_win_last), 320'(0));
    chk({tag, "_out_frame_last"}, 320'(out_frame_last), 320'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, t0, t1, t2;
    rst_n = 1'b0;
    clear = 1'b0;
    win_valid = 1'b0;
    win_data = '0;
    for (int k = 0; k < CH; k++) mem[k] = {i2f(k), {9{32'h3F800000}}};
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic window: all ones, bias k -> results 9.0+k.
    send_window({9{32'h3F800000}}, t);
    wait_idle();

    // Back-to-back windows with win_valid held and win_data churning while busy.
    rand_mem();
    win_valid = 1'b1;
    win_data = rand_win();
    wait_hs(t0, 200);
    repeat (40) begin win_data = rand_win(); @(posedge clk); #1; end
    win_data = rand_win();
    wait_hs(t1, 200);
    repeat (40) begin win_data = rand_win(); @(posedge clk); #1; end
    win_data = rand_win();
    wait_hs(t2, 200);
    win_valid = 1'b0;
    chk("hs_spacing_1", 320'(t1 - t0), 320'(CH + PL + 3));
    chk("hs_spacing_2", 320'(t2 - t1), 320'(CH + PL + 3));
    wait_idle();

    // Fifth window of the frame sequence starts the next frame.
    send_window(rand_win(), t);
    wait_idle();

    // Abort mid-window with clear, then a normal window.
    send_window(rand_win(), t);
    while (cyc < t + 19) begin @(posedge clk); #1; end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    send_window(rand_win(), t);
    wait_idle();

    // Asynchronous reset during DRAIN, between clock edges.
    send_window(rand_win(), t);
    while (cyc < t + 38) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random tail: fresh weights, random gaps, crosses another frame boundary.
    for (int n = 0; n < 5; n++) begin
      wait_idle();
      if ($urandom_range(0, 1) == 1) rand_mem();
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send_window(rand_win(), t);
    end
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 320'(exp_q.size()), 320'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
